useq: RTL and testbench

Parametrised microcode sequencer for the CPU core. It generalises the fixed three-slot next-address logic into a block with configurable address width, dispatch slot count, interrupt entry and an optional micro-subroutine stack. It sits between the microcode ROM output (the sequencing fields of the current microword) and the microcode ROM address input. It also issues opcode-dispatch ROM read requests.

---
 rtl/useq_pkg.sv | 21 ++
 rtl/useq_stack.sv | 40 ++++
 rtl/useq.sv | 158 +++++++++++++++
 tb/tb_useq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/useq_pkg.sv
// Shared types for the microcode sequencer: next-address ops and interrupt-entry kinds.
package useq_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_FETCH    = 3'd1,
    SEQ_DISPATCH = 3'd2,
    SEQ_BRANCH   = 3'd3,
    SEQ_JUMP     = 3'd4,
    SEQ_CALL     = 3'd5,
    SEQ_RET      = 3'd6
  } seq_op_t;

  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_IRQ  = 2'd1,
    INT_NMI  = 2'd2,
    INT_RST  = 2'd3
  } int_kind_t;

endpackage

// File: rtl/useq_stack.sv
// Micro-subroutine return stack: small LIFO, synchronous active-low reset clears the pointer.
module useq_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;

  assign full  = (sp == PW'(DEPTH));
  assign empty = (sp == '0);
  assign top   = mem[IW'(sp - 1'b1)];

  always_ff @(posedge clk) begin
    if (!n_reset)
      sp <= '0;
    else if (push && !full)
      sp <= sp + 1'b1;
    else if (pop && !empty)
      sp <= sp - 1'b1;
  end

  // Storage needs no reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (n_reset && push && !full)
      mem[IW'(sp)] <= din;
  end

endmodule

// File: rtl/useq.sv
// Microcode next-address sequencer with interrupt entry and opcode dispatch.
// Optional return stack enabled by defining USEQ_CALL_EN.
module useq
  import useq_pkg::*;
#(
  parameter int AW          = 10,
  parameter int NSLOT       = 3,
  parameter int STACK_DEPTH = 4,
  parameter int FETCH_ADDR  = 0,
  parameter int RST_ENTRY   = 1,
  parameter int IRQ_ENTRY   = 2,
  parameter int NMI_ENTRY   = 3,
  localparam int SW         = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              rdy,
  input  logic [2:0]        ctl_op,
  input  logic [SW-1:0]     ctl_sel,
  input  logic [AW-1:0]     ctl_target,
  input  logic              cond,
  input  logic              disp_valid,
  input  logic [NSLOT*AW-1:0] disp_addr,
  input  logic              irq,
  input  logic              nmi,
  input  logic              i_flag,
  output logic [AW-1:0]     mop_addr,
  output logic              at_fetch,
  output logic              disp_req,
  output logic [1:0]        int_kind,
  output logic              err
);
  localparam logic [AW-1:0] FETCH_A = AW'(FETCH_ADDR);
  localparam logic [AW-1:0] RST_A   = AW'(RST_ENTRY);
  localparam logic [AW-1:0] IRQ_A   = AW'(IRQ_ENTRY);
  localparam logic [AW-1:0] NMI_A   = AW'(NMI_ENTRY);

  logic          nmi_prev, nmi_pend;
  logic [AW-1:0] inc, nxt_addr, f_addr;
  int_kind_t     kind_q, nxt_kind, f_kind;
  logic          set_err, take_nmi, f_nmi;
  logic          push, pop, stk_full, stk_empty;
  logic [AW-1:0] stk_top;

  assign inc      = mop_addr + 1'b1;
  assign at_fetch = (mop_addr == FETCH_A);
  assign int_kind = kind_q;

  // Interrupt priority evaluated at every fetch point.
  always_comb begin
    f_addr = FETCH_A;
    f_kind = INT_NONE;
    f_nmi  = 1'b0;
    if (nmi_pend) begin
      f_addr = NMI_A;
      f_kind = INT_NMI;
      f_nmi  = 1'b1;
    end else if (irq && !i_flag) begin
      f_addr = IRQ_A;
      f_kind = INT_IRQ;
    end
  end

  always_comb begin
    nxt_addr = mop_addr;
    nxt_kind = kind_q;
    set_err  = 1'b0;
    take_nmi = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    case (ctl_op)
      SEQ_NEXT:   nxt_addr = inc;
      SEQ_FETCH: begin
        nxt_addr = f_addr;
        nxt_kind = f_kind;
        take_nmi = f_nmi;
      end
      SEQ_DISPATCH: begin
        if (int'(ctl_sel) >= NSLOT) begin
          nxt_addr = FETCH_A;
          set_err  = 1'b1;
        end else if (disp_valid) begin
          nxt_addr = disp_addr[int'(ctl_sel)*AW +: AW];
        end
      end
      SEQ_BRANCH: nxt_addr = cond ? ctl_target : inc;
      SEQ_JUMP:   nxt_addr = ctl_target;
`ifdef USEQ_CALL_EN
      SEQ_CALL: begin
        nxt_addr = ctl_target;
        push     = rdy && !stk_full;
        set_err  = stk_full;
      end
      SEQ_RET: begin
        if (stk_empty) begin
          nxt_addr = FETCH_A;
          set_err  = 1'b1;
        end else begin
          nxt_addr = stk_top;
          pop      = rdy;
        end
      end
`else
      SEQ_CALL:   nxt_addr = ctl_target;
      // Without a stack, RET degrades to a fetch and flags the misuse.
      SEQ_RET: begin
        nxt_addr = f_addr;
        nxt_kind = f_kind;
        take_nmi = f_nmi;
        set_err  = 1'b1;
      end
`endif
      default: begin
        nxt_addr = FETCH_A;
        set_err  = 1'b1;
      end
    endcase
  end

`ifdef USEQ_CALL_EN
  useq_stack #(.DEPTH(STACK_DEPTH), .W(AW)) u_stack (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push),
    .pop     (pop),
    .din     (inc),
    .top     (stk_top),
    .full    (stk_full),
    .empty   (stk_empty)
  );
`else
  assign stk_top   = '0;
  assign stk_full  = 1'b0;
  assign stk_empty = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      mop_addr <= RST_A;
      kind_q   <= INT_RST;
      disp_req <= 1'b0;
      err      <= 1'b0;
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      // Edge detect runs through stalls; a new edge beats consumption.
      nmi_prev <= nmi;
      nmi_pend <= (nmi && !nmi_prev) || (nmi_pend && !(rdy && take_nmi));
      if (rdy) begin
        mop_addr <= nxt_addr;
        kind_q   <= nxt_kind;
        disp_req <= (nxt_addr == FETCH_A);
        err      <= err | set_err;
      end
    end
  end

endmodule

// File: tb/tb_useq.sv
// Self-checking bench for useq: directed test-plan sequences then randomized ops vs a queue-based model.
module tb_useq;
  import useq_pkg::*;

  localparam int AW = 10, NSLOT = 3, SDEPTH = 4;
  localparam int FA = 0, RA = 1, IA = 2, NA = 3;
  localparam int SW = $clog2(NSLOT);
  localparam int MOD = 1 << AW;

  logic clk = 1'b0;
  logic n_reset, rdy, cond, disp_valid, irq, nmi, i_flag;
  logic [2:0] ctl_op;
  logic [SW-1:0] ctl_sel;
  logic [AW-1:0] ctl_target;
  logic [NSLOT*AW-1:0] disp_addr;
  logic [AW-1:0] mop_addr;
  logic at_fetch, disp_req, err;
  logic [1:0] int_kind;

  int n_pass = 0, n_total = 0;

  // Reference state
  int m_addr, m_kind, m_req, m_err, m_pend, m_prev;
  int stk[$];

  always #5 clk = ~clk;

  useq #(.AW(AW), .NSLOT(NSLOT), .STACK_DEPTH(SDEPTH), .FETCH_ADDR(FA),
         .RST_ENTRY(RA), .IRQ_ENTRY(IA), .NMI_ENTRY(NA)) dut (
    .clk(clk), .n_reset(n_reset), .rdy(rdy), .ctl_op(ctl_op), .ctl_sel(ctl_sel),
    .ctl_target(ctl_target), .cond(cond), .disp_valid(disp_valid), .disp_addr(disp_addr),
    .irq(irq), .nmi(nmi), .i_flag(i_flag), .mop_addr(mop_addr), .at_fetch(at_fetch),
    .disp_req(disp_req), .int_kind(int_kind), .err(err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic fetch_pick(output int a, output int k, output bit took);
    took = 0;
    if (m_pend != 0) begin a = NA; k = 2; took = 1; end
    else if (irq && !i_flag) begin a = IA; k = 1; end
    else begin a = FA; k = 0; end
  endtask

  // Advance one clock: model computes next state from the spec rules, then outputs are compared.
  task automatic tick();
    int na, nk, inc;
    bit took, e, edge_n;
    na = m_addr; nk = m_kind; took = 0; e = 0;
    inc = (m_addr + 1) % MOD;
    edge_n = nmi && (m_prev == 0);
    if (!n_reset) begin
      stk.delete();
      m_addr = RA; m_kind = 3; m_req = 0; m_err = 0; m_pend = 0; m_prev = 0;
    end else begin
      if (rdy) begin
        case (ctl_op)
          3'd0: na = inc;
          3'd1: fetch_pick(na, nk, took);
          3'd2: begin
            if (int'(ctl_sel) >= NSLOT) begin na = FA; e = 1; end
            else if (disp_valid) na = int'(disp_addr[int'(ctl_sel)*AW +: AW]);
          end
          3'd3: na = cond ? int'(ctl_target) : inc;
          3'd4: na = int'(ctl_target);
`ifdef USEQ_CALL_EN
          3'd5: begin
            if (stk.size() >= SDEPTH) e = 1; else stk.push_back(inc);
            na = int'(ctl_target);
          end
          3'd6: begin
            if (stk.size() == 0) begin na = FA; e = 1; end
            else na = stk.pop_back();
          end
`else
          3'd5: na = int'(ctl_target);
          3'd6: begin fetch_pick(na, nk, took); e = 1; end
`endif
          default: begin na = FA; e = 1; end
        endcase
        m_addr = na; m_kind = nk; m_req = (na == FA); m_err = m_err | e;
      end
      m_pend = (edge_n || (m_pend != 0 && !took)) ? 1 : 0;
      m_prev = nmi;
    end
    @(posedge clk); #1;
    chk("mop_addr", int'(mop_addr), m_addr);
    chk("int_kind", int'(int_kind), m_kind);
    chk("disp_req", int'(disp_req), m_req);
    chk("err", int'(err), m_err);
    chk("at_fetch", int'(at_fetch), (m_addr == FA) ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic op(input int o, input int tgt = 0);
    ctl_op = 3'(o); ctl_target = AW'(tgt);
    tick();
  endtask

  initial begin
    logic [AW-1:0] slot1;
    n_reset = 0; rdy = 1; ctl_op = 0; ctl_sel = 0; ctl_target = 0; cond = 0;
    disp_valid = 0; disp_addr = '0; irq = 0; nmi = 0; i_flag = 0;
    @(negedge clk);
    tick();
    chk("rst_addr", int'(mop_addr), 1);
    chk("rst_kind", int'(int_kind), 3);
    n_reset = 1;

    // NEXT x3 from reset entry, nmi pulse, then three fetches
    op(0); op(0); op(0);
    chk("next3", int'(mop_addr), 4);
    chk("kind_hold", int'(int_kind), 3);
    nmi = 1; op(0);
    nmi = 0; op(0);
    irq = 1; op(1);
    chk("nmi_entry", int'(mop_addr), 3);
    chk("nmi_kind", int'(int_kind), 2);
    op(1);
    chk("irq_entry", int'(mop_addr), 2);
    chk("irq_kind", int'(int_kind), 1);
    i_flag = 1; op(1);
    chk("masked_fetch", int'(mop_addr), 0);
    chk("fetch_req", int'(disp_req), 1);
    irq = 0; i_flag = 0;

    // Dispatch wait then slot 1
    slot1 = 10'h120;
    disp_addr = {10'h0AA, slot1, 10'h055};
    ctl_sel = 1; disp_valid = 0;
    op(2); op(2);
    chk("disp_hold", int'(mop_addr), 0);
    disp_valid = 1; op(2);
    chk("disp_slot1", int'(mop_addr), 'h120);
    disp_valid = 0;

    // Wrap and branch
    op(4, 'h3FF); op(0);
    chk("wrap", int'(mop_addr), 0);
    op(4, 'h010);
    cond = 0; op(3, 'h155);
    chk("br_not", int'(mop_addr), 'h011);
    cond = 1; op(3, 'h155);
    chk("br_taken", int'(mop_addr), 'h155);
    cond = 0;

`ifdef USEQ_CALL_EN
    op(4, 'h050);
    op(5, 'h200); chk("call1", int'(mop_addr), 'h200);
    op(0);
    op(5, 'h300); chk("call2", int'(mop_addr), 'h300);
    op(6); chk("ret1", int'(mop_addr), 'h202);
    op(6); chk("ret2", int'(mop_addr), 'h051);
    chk("no_err_yet", int'(err), 0);
    for (int i = 0; i < SDEPTH + 1; i++) op(5, 'h100 + i);
    chk("overflow_err", int'(err), 1);
`else
    op(5, 'h222); chk("call_as_jump", int'(mop_addr), 'h222);
    op(6); chk("ret_as_fetch", int'(mop_addr), 0);
    chk("ret_err", int'(err), 1);
`endif

    // Stall with an NMI edge arriving mid-stall
    op(4, 'h077);
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      nmi = (i >= 2);
      op(0);
    end
    chk("stall_frozen", int'(mop_addr), 'h077);
    rdy = 1; nmi = 0;
    op(0);
    op(1);
    chk("post_stall_nmi", int'(mop_addr), 3);

    // Randomized phase, with occasional resets mid-routine
    for (int i = 0; i < 3000; i++) begin
      n_reset = ($urandom_range(0, 199) != 0);
      rdy = ($urandom_range(0, 7) != 0);
      ctl_op = 3'($urandom_range(0, 7));
      ctl_sel = SW'($urandom_range(0, 3));
      ctl_target = AW'($urandom);
      cond = 1'($urandom);
      disp_valid = 1'($urandom);
      disp_addr = (NSLOT*AW)'({$urandom, $urandom});
      irq = 1'($urandom);
      nmi = ($urandom_range(0, 5) == 0);
      i_flag = 1'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
